phase_error_detector: RTL
=========================

// Module: phase_error_detector
// PURPOSE
//  Counter-based digital phase/frequency detector, directly upstream of the loop filter's error_i.
//  Samples the reference and DCO feedback clocks in the gen_clk domain.
//  Measures the gen_clk-cycle distance between their rising edges.
//  Emits one signed error impulse per measurement; the loop filter integrates every cycle, so the error is zero otherwise.
//  Also flags cycle slips and reports lock.
// PARAMETERS
//  ERROR_WIDTH     8   width of signed error_o; magnitude saturates at ERR_MAX = 2^(ERROR_WIDTH-1)-1
//  SYNC_STAGES     2   synchronizer flops per async input (>=2)
//  LOCK_TOL        2   max |error| counted as in-lock
//  LOCK_COUNT      16  consecutive in-lock measurements needed to assert lock_o
//  LOCK_CNT_WIDTH  5   width of lock run counter (must hold LOCK_COUNT)
// PORTS
//  gen_clk_i      in   1            system clock (same clock as the loop filter)
//  reset_i        in   1            synchronous, active-high reset
//  enable_i       in   1            measurement enable
//  ref_clk_i      in   1            reference clock, async to gen_clk_i
//  fb_clk_i       in   1            DCO feedback clock, async to gen_clk_i
//  error_o        out  ERROR_WIDTH  signed phase error impulse, registered
//  error_valid_o  out  1            high for exactly the cycle error_o carries a measurement
//  slip_o         out  1            one-cycle pulse on a timeout or same-source repeat edge
//  lock_o         out  1            lock indicator, registered
// BEHAVIOUR
//  Reset (clock edge with reset_i=1): error_o=0, error_valid_o=0, slip_o=0, lock_o=0.
//   Also clears the FSM to IDLE, the counter, the lock run count and all synchronizer flops.
//   Reset mid-measurement discards the measurement; no output is produced.
//  Edge detect: rise_ref / rise_fb are single-cycle pulses.
//   A pulse occurs SYNC_STAGES+1 cycles after an input rise that meets setup.
//  FSM states and transitions:
//   IDLE     rise_ref&rise_fb -> emit 0, stay IDLE; rise_ref only -> REF_LEAD, cnt=0; rise_fb only -> FB_LEAD, cnt=0.
//   REF_LEAD cnt++ each cycle.
//            rise_fb -> emit +k, go IDLE (k = cycles since first edge; edge in next cycle gives k=1).
//            rise_ref (with or without rise_fb) -> emit +ERR_MAX, pulse slip_o, cnt=0, stay REF_LEAD.
//   FB_LEAD  mirror of REF_LEAD with negative sign (-k, -ERR_MAX).
//   Timeout  when cnt reaches ERR_MAX with no closing edge: emit +/-ERR_MAX per leading source, pulse slip_o, go IDLE.
//  Sign convention: ref leading (DCO slow) -> positive error, which raises dco_cc.
//  Output timing:
//   "Emit v": error_o=v and error_valid_o=1 on the cycle after the deciding edge pulse.
//   error_o=0 and error_valid_o=0 on every other cycle.
//   Total latency from input rise to error_o is SYNC_STAGES+2 cycles.
//  Saturation: |k| is clamped to ERR_MAX; the value -2^(ERROR_WIDTH-1) is never produced.
//  Lock:
//   Run counter += 1 on each valid measurement with |error| <= LOCK_TOL.
//   The run counter saturates at LOCK_COUNT; lock_o=1 once it reaches LOCK_COUNT.
//   Any valid measurement with |error| > LOCK_TOL, any slip, or enable_i=0 clears the run counter and lock_o on the same output cycle.
//  enable_i=0: FSM is forced to IDLE and cnt=0; no outputs are produced. Synchronizers keep running.
//   On re-enable, measurement restarts only from a fresh edge.
// STRUCTURE
//  Package adpll_pkg holds:
//   - FSM state encodings ST_IDLE, ST_REF_LEAD, ST_FB_LEAD
//   - function err_sat(width, magnitude, sign) returning the clamped signed value
//  Sub-module edge_sync:
//   - SYNC_STAGES flop chain plus a delayed copy, giving a rise pulse
//   - synchronous reset
//   - instantiated once for ref_clk_i and once for fb_clk_i
//  Top level holds the FSM, cnt (ERROR_WIDTH-1 bits), output registers and lock logic.
// TESTING
//  1 ref rises, fb rises 5 gen_clk later -> one cycle error_o=+5, valid=1; then error_o=0.
//  2 fb leads ref by 3 cycles -> error_o=-3; both rise in the same cycle -> error_o=0 with valid=1.
//  3 ref only, no fb for 200 cycles -> at cnt=127: error_o=+127, slip_o=1, state IDLE; no further output.
//  4 two ref rises 10 cycles apart, no fb -> second rise gives error_o=+127 and slip_o=1.
//    A fb rise 4 cycles later then gives error_o=+4.
//  5 16 measurements with |err|<=2 -> lock_o rises at the 16th output.
//    A 17th measurement with err=+3 -> lock_o=0 on that cycle.
//  6 reset_i pulsed mid-REF_LEAD -> outputs 0 next cycle.
//    A subsequent fb rise gives FB_LEAD, not a +k measurement.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL phase/frequency detector.
//   pd_state_e : detector FSM states (idle, reference leading, feedback leading)
//   err_sat    : clamps a magnitude to the signed error range and applies the sign.
//                The most negative code is never produced, so the error range is
//                symmetric about zero.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REF_LEAD = 2'd1,
        ST_FB_LEAD  = 2'd2
    } pd_state_e;

    function automatic int err_sat(input int width, input int magnitude, input logic negative);
        int err_max;
        int mag;
        err_max = (1 << (width - 1)) - 1;
        mag     = (magnitude > err_max) ? err_max : magnitude;
        return negative ? -mag : mag;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous clock-like input into the clk domain and
// produces a registered one-cycle pulse for each rising edge.
//   clk     : sampling clock
//   srst    : synchronous active-high reset, clears the whole chain
//   async_i : asynchronous input
//   rise_o  : one-cycle pulse, SYNC_STAGES+1 cycles after a rise that meets setup
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;
    logic                   rise_q;
    logic                   rise_d;

    assign sync_d[0] = async_i;

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    // The delayed copy of the last stage turns a level into a single-cycle rise pulse.
    always_comb begin
        dly_d  = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~dly_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/phase_error_detector.sv
// Counter-based phase/frequency detector feeding the loop filter.
// Measures the gen_clk distance between synchronized reference and feedback
// rising edges and emits one signed, saturated error impulse per measurement.
//   gen_clk_i     : system clock
//   reset_i       : synchronous active-high reset
//   enable_i      : measurement enable (low forces idle, clears lock)
//   ref_clk_i     : reference clock, asynchronous
//   fb_clk_i      : DCO feedback clock, asynchronous
//   error_o       : signed error impulse (positive when reference leads)
//   error_valid_o : high only on the cycle error_o carries a measurement
//   slip_o        : one-cycle pulse on timeout or a repeated leading edge
//   lock_o        : high after LOCK_COUNT consecutive small errors
module phase_error_detector #(
    parameter int ERROR_WIDTH    = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_TOL       = 2,
    parameter int LOCK_COUNT     = 16,
    parameter int LOCK_CNT_WIDTH = 5
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic                          ref_clk_i,
    input  logic                          fb_clk_i,
    output logic signed [ERROR_WIDTH-1:0] error_o,
    output logic                          error_valid_o,
    output logic                          slip_o,
    output logic                          lock_o
);
    import adpll_pkg::*;

    localparam int ERR_MAX = (1 << (ERROR_WIDTH - 1)) - 1;
    localparam int CNT_W   = ERROR_WIDTH - 1;

    logic rise_ref;
    logic rise_fb;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk     (gen_clk_i),
        .srst    (reset_i),
        .async_i (ref_clk_i),
        .rise_o  (rise_ref)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .clk     (gen_clk_i),
        .srst    (reset_i),
        .async_i (fb_clk_i),
        .rise_o  (rise_fb)
    );

    pd_state_e                    state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [LOCK_CNT_WIDTH-1:0]    run_q, run_d;
    logic signed [ERROR_WIDTH-1:0] error_q, error_d;
    logic                         valid_q, valid_d;
    logic                         slip_q, slip_d;
    logic                         lock_q, lock_d;

    logic emit;
    logic emit_neg;
    logic emit_slip;
    int   emit_mag;
    int   err_full;
    logic lead_neg;
    logic own_edge;
    logic other_edge;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        error_d    = '0;
        valid_d    = 1'b0;
        slip_d     = 1'b0;
        emit       = 1'b0;
        emit_neg   = 1'b0;
        emit_slip  = 1'b0;
        emit_mag   = 0;
        err_full   = 0;
        lead_neg   = 1'b0;
        own_edge   = 1'b0;
        other_edge = 1'b0;

        if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            run_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (rise_ref && rise_fb) begin
                        emit = 1'b1;
                    end else if (rise_ref) begin
                        state_d = ST_REF_LEAD;
                    end else if (rise_fb) begin
                        state_d = ST_FB_LEAD;
                    end
                end
                ST_REF_LEAD, ST_FB_LEAD: begin
                    // Both lead states share one path; only the sign and
                    // which source counts as "own" differ.
                    lead_neg   = (state_q == ST_FB_LEAD);
                    own_edge   = lead_neg ? rise_fb : rise_ref;
                    other_edge = lead_neg ? rise_ref : rise_fb;
                    emit_neg   = lead_neg;
                    cnt_d      = cnt_q + 1'b1;
                    if (own_edge) begin
                        // Second edge from the leading source: a slip, restart timing.
                        emit      = 1'b1;
                        emit_slip = 1'b1;
                        emit_mag  = ERR_MAX;
                        cnt_d     = '0;
                    end else if (other_edge) begin
                        emit     = 1'b1;
                        emit_mag = int'(cnt_q) + 1;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                    end else if (cnt_q == CNT_W'(ERR_MAX - 1)) begin
                        // This cycle would be distance ERR_MAX with no closing edge.
                        emit      = 1'b1;
                        emit_slip = 1'b1;
                        emit_mag  = ERR_MAX;
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (emit) begin
                err_full = err_sat(ERROR_WIDTH, emit_mag, emit_neg);
                error_d  = err_full[ERROR_WIDTH-1:0];
                valid_d  = 1'b1;
                slip_d   = emit_slip;
                if (!emit_slip && emit_mag <= LOCK_TOL) begin
                    run_d = (run_q == LOCK_CNT_WIDTH'(LOCK_COUNT)) ? run_q : run_q + 1'b1;
                end else begin
                    run_d = '0;
                end
            end
        end

        lock_d = (run_d == LOCK_CNT_WIDTH'(LOCK_COUNT));
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            run_q   <= '0;
            error_q <= '0;
            valid_q <= 1'b0;
            slip_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            error_q <= error_d;
            valid_q <= valid_d;
            slip_q  <= slip_d;
            lock_q  <= lock_d;
        end
    end

    assign error_o       = error_q;
    assign error_valid_o = valid_q;
    assign slip_o        = slip_q;
    assign lock_o        = lock_q;

endmodule
